// File: rtl/mem_bus_fabric_if.sv
// CPU-side native memory port plus the fanned-out slave channels.
// The fabric takes the slave modport; the CPU/slave environment takes master.
interface mem_bus_fabric_if #(
  parameter int NUM_SLAVES = 8
);
  logic                    mem_valid;
  logic [31:0]             mem_addr;
  logic [3:0]              mem_wstrb;
  logic                    mem_ready;
  logic [31:0]             mem_rdata;
  logic [NUM_SLAVES-1:0]   slv_select;
  logic [NUM_SLAVES-1:0]   slv_ready;
  logic [32*NUM_SLAVES-1:0] slv_rdata;

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb,
    input  slv_ready, slv_rdata,
    output mem_ready, mem_rdata, slv_select
  );

  modport master (
    output mem_valid, mem_addr, mem_wstrb,
    output slv_ready, slv_rdata,
    input  mem_ready, mem_rdata, slv_select
  );
endinterface

// File: rtl/mem_bus_fabric.sv
// picorv32 native-port interconnect: base/mask decode, error capture/irq.
// Define BUS_TIMEOUT_EN to add the hung-slave watchdog.
module mem_bus_fabric #(
  parameter int NUM_SLAVES = 8,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic            clk,
  input  logic            reset,
  mem_bus_fabric_if.slave bus,
  input  logic            err_clear,
  output logic            bus_err_irq,
  output logic [31:0]     err_addr,
  output logic [2:0]      err_status
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_n
    $error("NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] hit, pick;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [31:0]           rdata_q, rdata_d, sel_rdata;
  logic                  ready_q, ready_d;
  logic                  err_valid_q, err_valid_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [2:0]            err_status_q, err_status_d;
  logic                  ack, expired, to_err, capture;
  logic [2:0]            cause;
  logic [31:0]           cause_addr, req_addr;
  logic                  req_wr;

  always_comb begin
    hit  = '0;
    pick = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      hit[i] = (bus.mem_addr & SLAVE_MASK[32*i +: 32])
               == SLAVE_BASE[32*i +: 32];
    // Walk downwards so the lowest-index hit is the one left standing.
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (hit[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_q[i]) sel_rdata |= bus.slv_rdata[32*i +: 32];
  end

  assign ack = |(bus.slv_ready & sel_q);

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_wr_q, req_wr_d;

  always_comb begin
    cnt_d      = (state_q == ACCESS) ? cnt_q + 16'd1 : '0;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    if (state_q == IDLE) begin
      req_addr_d = bus.mem_addr;
      req_wr_d   = |bus.mem_wstrb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_wr_q   <= req_wr_d;
    end
  end

  assign expired  = (cnt_q == CNT_LAST);
  assign req_addr = req_addr_q;
  assign req_wr   = req_wr_q;
`else
  assign expired  = 1'b0;
  assign req_addr = bus.mem_addr;
  assign req_wr   = |bus.mem_wstrb;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = '0;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    to_err     = 1'b0;
    cause      = '0;
    cause_addr = bus.mem_addr;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          if (|hit) begin
            sel_d   = pick;
            state_d = ACCESS;
          end else begin
            state_d = ERR;
            ready_d = 1'b1;
            rdata_d = ERR_RDATA;
            to_err  = 1'b1;
            cause   = {|bus.mem_wstrb, 1'b0, 1'b1};
          end
        end
      end
      ACCESS: begin
        // Ready beats the watchdog when both land on the same cycle.
        if (ack) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = sel_rdata;
        end else if (expired) begin
          state_d    = ERR;
          ready_d    = 1'b1;
          rdata_d    = ERR_RDATA;
          to_err     = 1'b1;
          cause      = {req_wr, 1'b1, 1'b0};
          cause_addr = req_addr;
        end else begin
          sel_d = sel_q;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture      = to_err && (!err_valid_q || err_clear);
    err_valid_d  = capture || (err_valid_q && !err_clear);
    err_addr_d   = capture ? cause_addr : err_addr_q;
    err_status_d = capture ? cause : err_status_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
      err_status_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
      err_status_q <= err_status_d;
    end
  end

  assign bus.slv_select = sel_q;
  assign bus.mem_ready  = ready_q;
  assign bus.mem_rdata  = rdata_q;
  assign bus_err_irq    = err_valid_q;
  assign err_addr       = err_addr_q;
  assign err_status     = err_status_q;

endmodule
